// File: rtl/program_rom_pkg.sv
// rtl/program_rom_pkg.sv - shared types, defaults and program image for the fetch unit
package program_rom_pkg;

  localparam int DW_DEF = 16;
  localparam int AW_DEF = 8;

  typedef enum logic {RUN, HALT} fetch_state_t;

  // Boot image: words 0..9 carry their address nibble in every digit, word 10 halts.
  function automatic logic [DW_DEF-1:0] rom_init(input logic [31:0] addr);
    if (addr <= 32'd9) begin
      rom_init = {4{addr[3:0]}};
    end else if (addr == 32'd10) begin
      rom_init = 16'hFFFF;
    end else begin
      rom_init = '0;
    end
  endfunction

endpackage

// File: rtl/program_rom_core.sv
// rtl/program_rom_core.sv - synchronous-read program ROM, unpopulated addresses read as zero
module program_rom_core
  import program_rom_pkg::*;
#(
  parameter int          DW    = DW_DEF,
  parameter int          AW    = AW_DEF,
  parameter int unsigned DEPTH = 256
) (
  input  logic          clk,
  input  logic          rd_en,
  input  logic [AW-1:0] addr,
  output logic [DW-1:0] data
);

  logic [DW-1:0] r_data;
  logic [DW-1:0] w_word;

  always_comb begin
    w_word = '0;
    if (32'(addr) < DEPTH) begin
      w_word = DW'(rom_init(32'(addr)));
    end
  end

  // Read register only loads on an issued fetch, so a stalled word stays put.
  always_ff @(posedge clk) begin
    if (rd_en) begin
      r_data <= w_word;
    end
  end

  assign data = r_data;

endmodule

// File: rtl/program_rom_fetch.sv
// rtl/program_rom_fetch.sv - PC sequencer with valid/ready output, jumps and HALT_WORD stop
module program_rom_fetch
  import program_rom_pkg::*;
#(
  parameter int            DW        = DW_DEF,
  parameter int            AW        = AW_DEF,
  parameter int unsigned   DEPTH     = 256,
  parameter logic [AW-1:0] RESET_PC  = '0,
  parameter logic [DW-1:0] HALT_WORD = DW'(16'hFFFF)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic          jump,
  input  logic [AW-1:0] jump_addr,
  output logic [DW-1:0] code,
  output logic [AW-1:0] code_pc,
  output logic          valid,
  input  logic          ready,
  output logic          halted
);

  fetch_state_t  r_state;
  logic [AW-1:0] r_pc;
  logic [AW-1:0] r_code_pc;
  logic          r_valid;
  logic          r_halted;
  logic          r_loaded;
  logic [DW-1:0] w_rom_data;
  logic          w_acc;
  logic          w_halt_acc;
  logic          w_iss;

  program_rom_core #(
    .DW    (DW),
    .AW    (AW),
    .DEPTH (DEPTH)
  ) u_core (
    .clk   (clk),
    .rd_en (w_iss),
    .addr  (r_pc),
    .data  (w_rom_data)
  );

  // The ROM read register has no reset; r_loaded forces code to zero until the first fetch.
  assign code       = r_loaded ? w_rom_data : '0;
  assign code_pc    = r_code_pc;
  assign valid      = r_valid;
  assign halted     = r_halted;

  assign w_acc      = r_valid & ready;
  assign w_halt_acc = w_acc & (code == HALT_WORD);
  assign w_iss      = (r_state == RUN) & en & ~jump & (~r_valid | ready) & ~w_halt_acc;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= RUN;
      r_pc      <= RESET_PC;
      r_code_pc <= '0;
      r_valid   <= 1'b0;
      r_halted  <= 1'b0;
      r_loaded  <= 1'b0;
    end else if (jump) begin
      r_state  <= RUN;
      r_pc     <= jump_addr;
      r_valid  <= 1'b0;
      r_halted <= 1'b0;
    end else begin
      if (w_iss) begin
        r_code_pc <= r_pc;
        r_valid   <= 1'b1;
        r_pc      <= r_pc + 1'b1;
        r_loaded  <= 1'b1;
      end else if (w_acc) begin
        r_valid <= 1'b0;
      end
      case (r_state)
        RUN: begin
          if (w_halt_acc) begin
            r_state  <= HALT;
            r_halted <= 1'b1;
          end
        end
        HALT: begin
          r_halted <= 1'b1;
        end
        default: r_state <= RUN;
      endcase
    end
  end

endmodule
